// File: rtl/bmem_gcd_sequencer.sv
// Sequencer for the block-memory -> GCD -> SPI datapath.
// Walks NUM_PAIRS operand pairs stored at BASE_ADDR, runs each pair through
// the GCD core (or bypasses it for a 0/0 pair) and hands every result byte
// to the SPI transmitter over a valid/ready handshake.
module bmem_gcd_sequencer #(
   parameter int DW        = 8,
   parameter int AW        = 5,
   parameter int NUM_PAIRS = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] gcd_a,
   output logic [DW-1:0] gcd_b,
   output logic          gcd_start,
   input  logic          gcd_done,
   input  logic [DW-1:0] gcd_result,
   output logic [DW-1:0] spi_data,
   output logic          spi_valid,
   input  logic          spi_ready,
   output logic          busy,
   output logic          done,
   output logic [AW-2:0] pair_idx
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_A,
      S_LATCH_A,
      S_LATCH_B,
      S_START,
      S_WAIT,
      S_SEND,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
   localparam logic [AW-2:0] LAST = (AW-1)'(NUM_PAIRS - 1);

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] a_reg;
   logic [AW-1:0] pair_addr;
   logic [AW-2:0] idx_inc;

   // Address arithmetic wraps modulo 2^AW by truncation.
   assign pair_addr = BASE + {pair_idx, 1'b0};
   assign idx_inc   = pair_idx + (AW-1)'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded control outputs.
   always_comb begin
      state_nxt = state;
      gcd_start = 1'b0;
      spi_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (go) state_nxt = S_FETCH_A;
         end
         S_FETCH_A: state_nxt = S_LATCH_A;
         S_LATCH_A: state_nxt = S_LATCH_B;
         S_LATCH_B: begin
            if (a_reg == '0 && mem_rdata == '0) state_nxt = S_SEND;
            else                                state_nxt = S_START;
         end
         S_START: begin
            gcd_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (gcd_done) state_nxt = S_SEND;
         end
         S_SEND: begin
            spi_valid = 1'b1;
            if (spi_ready) state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (pair_idx == LAST) state_nxt = S_DONE;
            else                  state_nxt = S_FETCH_A;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers: address, operand latches, result byte, pair index.
   // mem_addr is registered one state ahead so that the A address is on the
   // bus throughout FETCH_A and the B address throughout LATCH_A.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr <= BASE;
         a_reg    <= '0;
         gcd_a    <= '0;
         gcd_b    <= '0;
         spi_data <= '0;
         pair_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  pair_idx <= '0;
                  mem_addr <= BASE;
               end
            end
            S_FETCH_A: mem_addr <= pair_addr + AW'(1);
            S_LATCH_A: a_reg    <= mem_rdata;
            S_LATCH_B: begin
               if (a_reg == '0 && mem_rdata == '0) begin
                  spi_data <= '0;
               end else begin
                  gcd_a <= a_reg;
                  gcd_b <= mem_rdata;
               end
            end
            S_WAIT: begin
               if (gcd_done) spi_data <= gcd_result;
            end
            S_NEXT: begin
               if (pair_idx != LAST) begin
                  pair_idx <= idx_inc;
                  mem_addr <= BASE + {idx_inc, 1'b0};
               end
            end
            S_DONE: pair_idx <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/bmem_gcd_sequencer.md
Name: bmem_gcd_sequencer

Overview:
Controller that sequences the block-memory → GCD → SPI datapath. On a `go` pulse it walks NUM_PAIRS operand pairs stored consecutively in a synchronous-read block memory. For each pair it fetches operand A and operand B, launches the GCD core with a start/done handshake, and hands the 8-bit result to the SPI transmitter through a valid/ready handshake. It sits between the top-level wrapper control and the memory, GCD and SPI instances.

Parameters:
DW, 8, operand/result width in bits
AW, 5, block-memory address width
NUM_PAIRS, 8, operand pairs processed per run (1..2^(AW-1))
BASE_ADDR, 0, memory address of the first operand A

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  start a run; sampled only in IDLE
mem_addr  out  AW  block-memory read address
mem_rdata  in  DW  block-memory read data, valid one cycle after mem_addr
gcd_a  out  DW  GCD operand A, held stable from START through WAIT
gcd_b  out  DW  GCD operand B, held stable from START through WAIT
gcd_start  out  1  one-cycle start pulse to the GCD core
gcd_done  in  1  GCD core completion; may be level or pulse
gcd_result  in  DW  GCD result, valid while gcd_done=1
spi_data  out  DW  byte to transmit
spi_valid  out  1  byte available for SPI
spi_ready  in  1  SPI accepts a byte when valid&&ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the run completes
pair_idx  out  AW-1  index of the pair currently being processed

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE
  - mem_addr=BASE_ADDR
  - gcd_a=gcd_b=0, spi_data=0, pair_idx=0
  - gcd_start=spi_valid=busy=done=0
  - Reset mid-run aborts immediately. No pending spi_valid or gcd_start survives.
- States and transitions:
  - IDLE: busy=0. On go=1, set pair_idx=0, mem_addr=BASE_ADDR, go to FETCH_A.
  - FETCH_A: mem_addr=BASE_ADDR+2*pair_idx. Go to LATCH_A.
  - LATCH_A: capture mem_rdata into A register; mem_addr=BASE_ADDR+2*pair_idx+1. Go to LATCH_B.
  - LATCH_B: capture mem_rdata into B register.
    - If A==0 and B==0: spi_data=0, go to SEND (GCD core bypassed).
    - Else go to START.
  - START: gcd_start=1 for exactly this cycle; gcd_a and gcd_b driven from the registers. Go to WAIT.
  - WAIT: gcd_start=0. On gcd_done=1, capture gcd_result into spi_data and go to SEND. gcd_done in the same cycle as START is ignored.
  - SEND: spi_valid=1, spi_data held stable. When spi_ready=1, drop spi_valid next cycle and go to NEXT. spi_ready=1 on the first SEND cycle completes the transfer in that single cycle.
  - NEXT:
    - If pair_idx==NUM_PAIRS-1: go to DONE.
    - Else pair_idx+=1 and go to FETCH_A.
  - DONE: done=1 for one cycle, pair_idx reset to 0, go to IDLE.
- Handshake and boundary rules:
  - go is ignored while busy. go held high after DONE starts a new run from IDLE on the next edge.
  - Address arithmetic is modulo 2^AW. Wrap-around past the top address is legal and is not flagged.
  - Exactly one spi_valid transfer occurs per pair, in pair order.
  - Minimum per-pair latency with GCD bypass: 5 cycles (FETCH_A, LATCH_A, LATCH_B, SEND, NEXT).
  - Minimum per-pair latency with GCD: 7 cycles, plus GCD compute time, plus SPI stall.
  - The spi_data, gcd_a and gcd_b registers change only in the states named above.

Test Plan:
1. Memory {48,18,35,14} with NUM_PAIRS=2; GCD model has 3-cycle latency; spi_ready tied high; pulse go → SPI bytes 6 then 7; exactly two gcd_start pulses; done pulses once; busy returns to 0.
2. Pair (0,0) → GCD core never started; SPI byte 0. Pair (0,9) → GCD started; SPI byte 9.
3. spi_ready held low for 10 cycles in SEND → spi_valid stays high and spi_data stays at 6 throughout; transfer completes on the first cycle spi_ready=1.
4. rst asserted during WAIT of pair 1 → next cycle state=IDLE and all outputs at reset values; a subsequent go restarts from pair 0 (address BASE_ADDR).
5. go pulsed again during a run → ignored; done pulses once; SPI byte count equals NUM_PAIRS.
6. AW=3, BASE_ADDR=6, NUM_PAIRS=2 → read addresses 6,7,0,1 (wrap-around); results emitted for both pairs in order.
